// File: rtl/axis_chk_pkg.sv
// Shared types and constants for the AXI-Stream frame checker and its
// matching stream source.
package axis_chk_pkg;

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        LOCK = 1'b1
    } chk_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Fibonacci step: shift left, feedback is the parity of the tapped bits.
    function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), seeded at reset.
module lfsr16
    import axis_chk_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state
);

    logic [15:0] state_r;

    // Advance every cycle, independent of any handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= LFSR_SEED;
        end else begin
            state_r <= lfsr16_next(state_r);
        end
    end

    assign state = state_r;

endmodule

// File: rtl/axis_frame_checker.sv
// AXI-Stream sink that applies optional pseudo-random backpressure and checks
// that tlast lands on every FRAME_LEN-th accepted beat.
module axis_frame_checker #(
    parameter int WIDTH     = 32,
    parameter int FRAME_LEN = 2048,
    parameter int CNT_W     = 32,
    parameter int HUNT      = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             s_axis_tdata,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    input  logic                         bp_en,
    output logic [CNT_W-1:0]             frame_count,
    output logic [CNT_W-1:0]             err_count,
    output logic                         err_flag,
    output logic [$clog2(FRAME_LEN)-1:0] err_beat,
    output logic                         locked
);
    import axis_chk_pkg::*;

    localparam int               IDX_W     = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam chk_state_t       RST_STATE = (HUNT != 0) ? axis_chk_pkg::HUNT : axis_chk_pkg::LOCK;

    logic [15:0]      lfsr_s;
    logic             tready_r;
    chk_state_t       state_r,      state_nx_s;
    logic [IDX_W-1:0] beat_idx_r,   beat_idx_nx_s;
    logic [CNT_W-1:0] frame_cnt_r,  frame_cnt_nx_s;
    logic [CNT_W-1:0] err_cnt_r,    err_cnt_nx_s;
    logic             err_flag_r,   err_flag_nx_s;
    logic [IDX_W-1:0] err_beat_r,   err_beat_nx_s;
    logic             locked_r;
    logic             accept_s;
    logic             err_s;
    logic             unused_s;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr_s)
    );

    assign accept_s = s_axis_tvalid && tready_r;
    // Payload and upper LFSR bits play no part in framing.
    assign unused_s = ^{s_axis_tdata, lfsr_s[15:1]};

    // Next-state and frame position; early tlast still closes the frame so the
    // checker resyncs to the producer.
    always_comb begin
        state_nx_s     = state_r;
        beat_idx_nx_s  = beat_idx_r;
        frame_cnt_nx_s = frame_cnt_r;
        err_s          = 1'b0;
        case (state_r)
            axis_chk_pkg::HUNT: begin
                if (accept_s && s_axis_tlast) begin
                    state_nx_s    = axis_chk_pkg::LOCK;
                    beat_idx_nx_s = {IDX_W{1'b0}};
                end else begin
                    state_nx_s    = axis_chk_pkg::HUNT;
                end
            end
            axis_chk_pkg::LOCK: begin
                if (accept_s) begin
                    if (s_axis_tlast) begin
                        frame_cnt_nx_s = frame_cnt_r + CNT_W'(1'b1);
                        beat_idx_nx_s  = {IDX_W{1'b0}};
                        err_s          = (beat_idx_r != LAST_IDX);
                    end else if (beat_idx_r == LAST_IDX) begin
                        beat_idx_nx_s  = {IDX_W{1'b0}};
                        err_s          = 1'b1;
                    end else begin
                        beat_idx_nx_s  = beat_idx_r + IDX_W'(1'b1);
                    end
                end else begin
                    beat_idx_nx_s = beat_idx_r;
                end
            end
            default: begin
                state_nx_s    = RST_STATE;
                beat_idx_nx_s = {IDX_W{1'b0}};
            end
        endcase
    end

    // Error bookkeeping: saturating count, sticky flag, first-error position.
    always_comb begin
        err_cnt_nx_s  = err_cnt_r;
        err_flag_nx_s = err_flag_r;
        err_beat_nx_s = err_beat_r;
        if (err_s) begin
            if (err_cnt_r != CNT_MAX) begin
                err_cnt_nx_s = err_cnt_r + CNT_W'(1'b1);
            end else begin
                err_cnt_nx_s = err_cnt_r;
            end
            if (!err_flag_r) begin
                err_flag_nx_s = 1'b1;
                err_beat_nx_s = beat_idx_r;
            end else begin
                err_flag_nx_s = err_flag_r;
            end
        end else begin
            err_cnt_nx_s = err_cnt_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tready_r    <= 1'b0;
            state_r     <= RST_STATE;
            locked_r    <= (HUNT == 0);
            beat_idx_r  <= {IDX_W{1'b0}};
            frame_cnt_r <= {CNT_W{1'b0}};
            err_cnt_r   <= {CNT_W{1'b0}};
            err_flag_r  <= 1'b0;
            err_beat_r  <= {IDX_W{1'b0}};
        end else begin
            tready_r    <= !bp_en || lfsr_s[0];
            state_r     <= state_nx_s;
            locked_r    <= (state_nx_s == axis_chk_pkg::LOCK);
            beat_idx_r  <= beat_idx_nx_s;
            frame_cnt_r <= frame_cnt_nx_s;
            err_cnt_r   <= err_cnt_nx_s;
            err_flag_r  <= err_flag_nx_s;
            err_beat_r  <= err_beat_nx_s;
        end
    end

    assign s_axis_tready = tready_r;
    assign frame_count   = frame_cnt_r;
    assign err_count     = err_cnt_r;
    assign err_flag      = err_flag_r;
    assign err_beat      = err_beat_r;
    assign locked        = locked_r;

endmodule

// File: tb/tb_axis_frame_checker.sv
// Self-checking bench: two checkers (LOCK start / 32-bit counters, HUNT start /
// 4-bit counters) share one stream and are compared against a frame model.
module tb_axis_frame_checker;

    localparam int FL = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] tdata = 32'd0;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic        bp_en = 1'b0;

    logic        rdy0, rdy1, ef0, ef1, lk0, lk1;
    logic [31:0] fc0, ec0;
    logic [3:0]  fc1, ec1;
    logic [2:0]  eb0, eb1;

    always #5 clk = ~clk;

    axis_frame_checker #(.WIDTH(32), .FRAME_LEN(FL), .CNT_W(32), .HUNT(0)) dut (
        .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
        .s_axis_tlast(tlast), .s_axis_tready(rdy0), .bp_en(bp_en),
        .frame_count(fc0), .err_count(ec0), .err_flag(ef0), .err_beat(eb0), .locked(lk0));

    axis_frame_checker #(.WIDTH(32), .FRAME_LEN(FL), .CNT_W(4), .HUNT(1)) dut_h (
        .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
        .s_axis_tlast(tlast), .s_axis_tready(rdy1), .bp_en(bp_en),
        .frame_count(fc1), .err_count(ec1), .err_flag(ef1), .err_beat(eb1), .locked(lk1));

    int n_chk = 0;
    int n_pass = 0;

    // Reference model state (index 0 = dut, 1 = dut_h).
    logic [15:0] m_lfsr;
    bit          m_tready;
    bit          m_lk[2];
    bit          m_ef[2];
    longint      m_fc[2];
    longint      m_ec[2];
    int          m_pos[2];
    int          m_eb[2];

    typedef struct {
        string       name;
        int          nbeats;
        logic [63:0] last_mask;
        longint      fc;
        longint      ec;
        bit          ef;
        int          eb;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic longint cmax(input int k);
        return (k == 0) ? 64'hFFFF_FFFF : 64'd15;
    endfunction

    task automatic model_reset();
        m_lfsr   = 16'hACE1;
        m_tready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_lk[k] = (k == 0);
            m_ef[k] = 1'b0;
            m_fc[k] = 0;
            m_ec[k] = 0;
            m_pos[k] = 0;
            m_eb[k] = 0;
        end
    endtask

    // One accepted beat: a frame ends at tlast or after FL beats; any
    // disagreement between the two is a framing error.
    task automatic model_beat(input bit l);
        int  n;
        bit  bad;
        for (int k = 0; k < 2; k++) begin
            if (!m_lk[k]) begin
                if (l) begin
                    m_lk[k] = 1'b1;
                    m_pos[k] = 0;
                end
            end else begin
                n   = m_pos[k] + 1;
                bad = (l != (n == FL));
                if (l) m_fc[k] = (m_fc[k] + 1) % (cmax(k) + 1);
                if (bad) begin
                    if (m_ec[k] < cmax(k)) m_ec[k]++;
                    if (!m_ef[k]) begin
                        m_ef[k] = 1'b1;
                        m_eb[k] = m_pos[k];
                    end
                end
                m_pos[k] = (l || n == FL) ? 0 : n;
            end
        end
    endtask

    task automatic check_outputs();
        chk("tready0", rdy0, m_tready);
        chk("tready1", rdy1, m_tready);
        chk("locked0", lk0, m_lk[0]);
        chk("locked1", lk1, m_lk[1]);
        chk("frame_count0", fc0, m_fc[0]);
        chk("frame_count1", fc1, m_fc[1]);
        chk("err_count0", ec0, m_ec[0]);
        chk("err_count1", ec1, m_ec[1]);
        chk("err_flag0", ef0, m_ef[0]);
        chk("err_flag1", ef1, m_ef[1]);
        chk("err_beat0", eb0, m_eb[0]);
        chk("err_beat1", eb1, m_eb[1]);
    endtask

    // Present one cycle of stimulus; called at a falling edge, returns at the next.
    task automatic step(input bit v, input bit l);
        tvalid = v;
        tlast  = l;
        tdata  = $urandom;
        @(posedge clk);
        if (v && m_tready) model_beat(l);
        m_tready = !bp_en || m_lfsr[0];
        m_lfsr   = lfsr_adv(m_lfsr);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        tvalid = 1'b0;
        tlast  = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b1;
    endtask

    // Send n beats (tlast per mask bit), holding each beat until accepted.
    task automatic send_beats(input int n, input logic [63:0] mask);
        int i = 0;
        int guard = 0;
        bit a;
        while (i < n && guard < n * 20 + 50) begin
            a = m_tready;
            step(1'b1, mask[i]);
            if (a) i++;
            guard++;
        end
        if (i < n) chk("send_timeout", i, n);
    endtask

    initial begin
        int  acc_cnt;
        int  rdy_cnt;
        int  src;
        bit  v;
        bit  l;

        vecs[0] = '{"three_frames", 24, 64'h0000_0000_0080_8080, 64'd3, 64'd0, 1'b0, 0};
        vecs[1] = '{"early_last",   13, 64'h0000_0000_0000_1010, 64'd2, 64'd1, 1'b1, 4};
        vecs[2] = '{"missing_last", 16, 64'h0000_0000_0000_0000, 64'd0, 64'd2, 1'b1, 7};
        vecs[3] = '{"late_last",     9, 64'h0000_0000_0000_0100, 64'd1, 64'd2, 1'b1, 7};
        vecs[4] = '{"last_every",    3, 64'h0000_0000_0000_0007, 64'd3, 64'd3, 1'b1, 0};

        #1;
        @(negedge clk);

        // Table-driven frame scenarios, no backpressure.
        foreach (vecs[j]) begin
            bp_en = 1'b0;
            do_reset();
            send_beats(vecs[j].nbeats, vecs[j].last_mask);
            chk({vecs[j].name, "_fc"}, fc0, vecs[j].fc);
            chk({vecs[j].name, "_ec"}, ec0, vecs[j].ec);
            chk({vecs[j].name, "_ef"}, ef0, vecs[j].ef);
            chk({vecs[j].name, "_eb"}, eb0, vecs[j].eb);
        end

        // Backpressure: 1000 cycles with the source always valid.
        bp_en = 1'b1;
        do_reset();
        acc_cnt = 0;
        rdy_cnt = 0;
        for (int c = 0; c < 1000; c++) begin
            if (rdy0) rdy_cnt++;
            v = m_tready;
            step(1'b1, (acc_cnt % FL) == FL - 1);
            if (v) acc_cnt++;
        end
        chk("bp_ready_cycles", rdy_cnt, acc_cnt);
        chk("bp_frames", fc0, acc_cnt / FL);
        chk("bp_errors", ec0, 0);

        // HUNT alignment, then wrap and saturation of the 4-bit counters.
        bp_en = 1'b0;
        do_reset();
        send_beats(4, 64'h0);
        chk("hunt_not_locked", lk1, 0);
        send_beats(1, 64'h1);
        chk("hunt_locked", lk1, 1);
        send_beats(16, 64'h8080);
        chk("hunt_frames", fc1, 2);
        chk("hunt_errors", ec1, 0);
        chk("hunt_flag", ef1, 0);
        for (int f = 0; f < 16; f++) send_beats(FL, 64'h80);
        chk("frame_wrap", fc1, 2);
        for (int f = 0; f < 20; f++) send_beats(FL, 64'h0);
        chk("err_saturate", ec1, 15);
        chk("sat_err_beat", eb1, 7);
        chk("sat_frames", fc1, 2);

        // Reset mid-frame, then a clean restart at a frame boundary.
        do_reset();
        send_beats(3, 64'h0);
        rst = 1'b0;
        #1;
        chk("midrst_tready", rdy0, 0);
        chk("midrst_fc", fc0, 0);
        chk("midrst_ec", ec0, 0);
        chk("midrst_ef", ef0, 0);
        chk("midrst_eb", eb0, 0);
        chk("midrst_locked_h", lk1, 0);
        do_reset();
        send_beats(16, 64'h8080);
        chk("postrst_fc", fc0, 2);
        chk("postrst_ec", ec0, 0);
        chk("postrst_ef", ef0, 0);

        // Random traffic, gaps, toggling backpressure and occasional bad tlast.
        do_reset();
        src = 0;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 49) == 0) bp_en = ~bp_en;
            v = ($urandom_range(0, 3) != 0);
            l = ((src % FL) == FL - 1) ^ ($urandom_range(0, 19) == 0);
            if (v && m_tready) src++;
            step(v, l);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
